uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receive engine with a single-entry valid/ready
// output register and one-cycle framing-error / overrun pulses.
module uart_rx_core #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       busy
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  // Fewer than 4 clocks per bit leaves no room for mid-bit sampling.
  generate
    if (CPB < 4) begin : g_cpb_too_small
      $error("uart_rx_core: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shift_q, shift_d;
  logic            good_q, good_d;   // stop bit sampled 1 on this edge
  logic            bad_q, bad_d;     // stop bit sampled 0 on this edge
  logic            sync1_q, rx_s_q;
  logic [7:0]      rx_data_q;
  logic            rx_vld_q, frm_err_q, ovr_err_q;

  // Two-flop synchronizer; reset to idle-high so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Receiver state, bit timing and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic: half-bit wait to centre on the start bit, then full bits.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    good_d  = 1'b0;
    bad_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          bcnt_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bcnt_q == HALF_M1) begin
          bcnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;       // glitch, not a real start bit
          end else begin
            state_d = S_DATA;
            bidx_d  = '0;
          end
        end else begin
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bcnt_q == FULL_M1) begin
          bcnt_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          if (bidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bcnt_q == FULL_M1) begin
          bcnt_d = '0;
          if (rx_s_q) begin
            good_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bad_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a completing frame may reuse the slot freed by a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= 8'h00;
      rx_vld_q  <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      frm_err_q <= bad_q;
      ovr_err_q <= 1'b0;
      if (good_q) begin
        if (!rx_vld_q || rx_rdy) begin
          rx_data_q <= shift_q;
          rx_vld_q  <= 1'b1;
        end else begin
          ovr_err_q <= 1'b1;
        end
      end else if (rx_vld_q && rx_rdy) begin
        rx_vld_q <= 1'b0;
      end
    end
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames on rx; outputs checked every cycle
// against a frame-level model plus hand-computed literal expectations.
module tb_uart_rx_core;

  localparam int CPB  = 100;
  localparam int MAXC = 60000;
  // Edges from the cycle the pin is driven low until the outputs change:
  // 2 synchronizer edges + 1 to reach START, then CPB/2 + 9*CPB to the
  // stop sample, then one more edge for the output register.
  localparam int LAT  = 3 + CPB / 2 + 9 * CPB + 1;   // 954

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_rdy = 1'b0;
  logic       frm_err, ovr_err, busy;

  uart_rx_core #(.CLK_HZ(100000000), .BAUD(1000000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_vld(rx_vld),
    .rx_rdy(rx_rdy), .frm_err(frm_err), .ovr_err(ovr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Frame-level schedule: 0 none, 1 good byte, 2 framing error, per edge.
  int         ev_kind [MAXC];
  logic [7:0] ev_byte [MAXC];
  bit         busy_exp[MAXC];

  logic       rst_e = 1'b1, rdy_e = 1'b0;
  logic       rdy_level = 1'b0;
  bit         rdy_mode = 1'b0;
  logic [7:0] xfer_q[$];
  int         ovr_cnt = 0, frm_cnt = 0, busy_cnt = 0, last_rise = 0, last_start = 0;

  // model state
  logic       m_vld = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_frm = 1'b0, m_ovr = 1'b0, m_busy = 1'b0, vld_prev = 1'b0;

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      ev_kind[i] = 0;
      ev_byte[i] = 8'h00;
      busy_exp[i] = 1'b0;
    end
  end

  // Edge bookkeeping: inputs as seen by this edge and observed transfers.
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_e = rst;
    rdy_e = rx_rdy;
    if (rx_vld && rx_rdy) xfer_q.push_back(rx_data);
  end

  // rx_rdy source: a fixed level, or a pulse aligned with each scheduled completion.
  always @(posedge clk) begin
    #2;
    if (rdy_mode) rx_rdy = (cyc + 1 < MAXC) && (ev_kind[cyc + 1] == 1);
    else          rx_rdy = rdy_level;
  end

  // Model update for the edge just taken, then compare all outputs.
  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      if (rst_e) begin
        m_vld = 1'b0; m_data = 8'h00; m_frm = 1'b0; m_ovr = 1'b0;
      end else begin
        logic xfer;
        xfer  = m_vld && rdy_e;
        m_frm = (ev_kind[cyc] == 2);
        m_ovr = 1'b0;
        if (ev_kind[cyc] == 1) begin
          if (!m_vld || xfer) begin m_vld = 1'b1; m_data = ev_byte[cyc]; end
          else m_ovr = 1'b1;
        end else if (xfer) begin
          m_vld = 1'b0;
        end
      end
      m_busy = busy_exp[cyc];
      total++;
      if (rx_vld !== m_vld || rx_data !== m_data || frm_err !== m_frm ||
          ovr_err !== m_ovr || busy !== m_busy) begin
        bad++;
        $display("FAIL cycle_check c=%0d got vld=%b data=%h frm=%b ovr=%b busy=%b want vld=%b data=%h frm=%b ovr=%b busy=%b",
                 cyc, rx_vld, rx_data, frm_err, ovr_err, busy, m_vld, m_data, m_frm, m_ovr, m_busy);
      end
      if (ovr_err === 1'b1) ovr_cnt++;
      if (frm_err === 1'b1) frm_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (rx_vld === 1'b1 && vld_prev !== 1'b1) last_rise = cyc;
      vld_prev = rx_vld;
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
    else $display("ok %s = %0d", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one 8N1 frame; stop_low > 0 holds the stop bit low that many bit times.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    int n, last;
    logic [7:0] v;
    n = cyc;
    last_start = n;
    v = b;
    if (n + LAT < MAXC) begin
      ev_kind[n + LAT] = (stop_low == 0) ? 1 : 2;
      ev_byte[n + LAT] = b;
    end
    last = (stop_low == 0) ? n + LAT - 2 : n + (9 + stop_low) * CPB + 2;
    for (int k = n + 3; k <= last && k < MAXC; k++) busy_exp[k] = 1'b1;
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = v[i]; tick(CPB); end
    if (stop_low > 0) begin rx = 1'b0; tick(stop_low * CPB); end
    rx = 1'b1; tick(CPB);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_vld_busy", int'({rx_vld, busy, frm_err, ovr_err}), 0);

    // single byte, consumer always ready
    rdy_level = 1'b1;
    xfer_q.delete();
    send_frame(8'hA5, 0);
    tick(100);
    check("single_latency", last_rise - last_start, LAT);
    check("single_count", xfer_q.size(), 1);
    if (xfer_q.size() > 0) check("single_byte", int'(xfer_q[0]), 8'hA5);

    // backpressure then overrun
    rdy_level = 1'b0;
    ovr_cnt = 0;
    xfer_q.delete();
    send_frame(8'h12, 0);
    send_frame(8'h34, 0);
    tick(50);
    check("ovr_pulses", ovr_cnt, 1);
    check("held_byte", int'(rx_data), 8'h12);
    check("held_vld", int'(rx_vld), 1);
    rdy_level = 1'b1;
    tick(1);
    rdy_level = 1'b0;
    tick(1);
    check("drain_vld", int'(rx_vld), 0);
    check("drain_count", xfer_q.size(), 1);
    if (xfer_q.size() > 0) check("drain_byte", int'(xfer_q[0]), 8'h12);

    // framing error followed by a good frame
    rdy_level = 1'b1;
    frm_cnt = 0;
    xfer_q.delete();
    send_frame(8'h5A, 3);
    send_frame(8'h0F, 0);
    tick(50);
    check("frm_pulses", frm_cnt, 1);
    check("after_frm_count", xfer_q.size(), 1);
    if (xfer_q.size() > 0) check("after_frm_byte", int'(xfer_q[0]), 8'h0F);

    // 30-cycle glitch: busy until the start sample, nothing else
    begin
      int n;
      n = cyc;
      busy_cnt = 0; frm_cnt = 0; ovr_cnt = 0;
      xfer_q.delete();
      for (int k = n + 3; k <= n + 2 + CPB / 2; k++) busy_exp[k] = 1'b1;
      rx = 1'b0; tick(30);
      rx = 1'b1; tick(150);
      check("glitch_busy_cycles", busy_cnt, 50);
      check("glitch_events", xfer_q.size() + frm_cnt + ovr_cnt, 0);
    end

    // back-to-back stream, always ready
    ovr_cnt = 0;
    xfer_q.delete();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 0);
    tick(100);
    check("stream1_count", xfer_q.size(), 16);
    for (int i = 0; i < 16 && i < xfer_q.size(); i++) check("stream1_byte", int'(xfer_q[i]), i);
    check("stream1_ovr", ovr_cnt, 0);

    // back-to-back stream, transfer coincides with each completion
    rdy_mode = 1'b1;
    xfer_q.delete();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 0);
    tick(100);
    rdy_mode = 1'b0;
    rdy_level = 1'b1;
    tick(3);
    check("stream2_count", xfer_q.size(), 16);
    for (int i = 0; i < 16 && i < xfer_q.size(); i++) check("stream2_byte", int'(xfer_q[i]), i);
    check("stream2_ovr", ovr_cnt, 0);

    // reset in the middle of bit 4 of 0xFF
    xfer_q.delete();
    fork
      send_frame(8'hFF, 0);
      begin
        int n, k0;
        n = cyc;
        tick(550);
        rst = 1'b1;
        k0 = n + 551;
        for (int k = k0; k < n + LAT + 1 && k < MAXC; k++) busy_exp[k] = 1'b0;
        if (n + LAT < MAXC) ev_kind[n + LAT] = 0;
        tick(1);
        rst = 1'b0;
        check("midrst_outputs", int'({rx_vld, busy, frm_err, ovr_err}), 0);
        check("midrst_rx_data", int'(rx_data), 0);
      end
    join
    tick(50);
    check("midrst_no_byte", xfer_q.size(), 0);
    send_frame(8'h81, 0);
    tick(50);
    check("post_rst_count", xfer_q.size(), 1);
    if (xfer_q.size() > 0) check("post_rst_byte", int'(xfer_q[0]), 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
